priority_classifier: RTL and testbench
======================================

// Module: priority_classifier
// PURPOSE
//  Ingress end of the packet-scheduling path. Takes one AXI-Stream of frames and reads a priority field in each frame's first beat.
//  Steers the whole frame to one of N_QUEUE output streams, which feed the per-priority FIFOs (queue 0 = highest priority).
//  Frames are never split or interleaved across outputs; backpressure from the selected queue stalls the input.
// PARAMETERS
//  N_QUEUE          3   number of output queues (2..8)
//  AXIS_DATA_WIDTH  64  tdata width, bits
//  AXIS_KEEP_WIDTH  AXIS_DATA_WIDTH/8  tkeep width
//  PRIO_OFFSET      0   bit offset of priority field in first-beat tdata
//  PRIO_WIDTH       3   priority field width, bits (PRIO_OFFSET+PRIO_WIDTH <= AXIS_DATA_WIDTH)
// PORTS
//  clk                 in   1                        clock
//  rst                 in   1                        synchronous reset, active-high
//  s_axis_tdata        in   AXIS_DATA_WIDTH          input data
//  s_axis_tkeep        in   AXIS_KEEP_WIDTH          input byte enables
//  s_axis_tvalid       in   1                        input valid
//  s_axis_tready       out  1                        input ready
//  s_axis_tlast        in   1                        input end of frame
//  m_axis_tdata        out  N_QUEUE*AXIS_DATA_WIDTH  per-queue data, queue i at [i*W +: W]
//  m_axis_tkeep        out  N_QUEUE*AXIS_KEEP_WIDTH  per-queue byte enables
//  m_axis_tvalid       out  N_QUEUE                  per-queue valid (at most one bit set)
//  m_axis_tready       in   N_QUEUE                  per-queue ready
//  m_axis_tlast        out  N_QUEUE                  per-queue end of frame
//  status_frame_count  out  N_QUEUE*32               per-queue forwarded-frame counters
// BEHAVIOUR
//  Clock and reset: single clock clk; synchronous active-high reset rst. Reset holds every output at 0.
//  Reset also clears state to IDLE, the output register and the counters.
//  Datapath: one output register stage (out_valid, out_q, data/keep/last). Input-to-output latency is 1 clk.
//  Output valid: m_axis_tvalid[out_q] = out_valid; all other valid bits are 0.
//  Output data: tdata/tkeep/tlast are replicated on every lane; only the valid lane is meaningful.
//  Input ready: s_axis_tready = !out_valid || m_axis_tready[out_q]. This permits full throughput of 1 beat/clk.
//  Output hold: out_valid, data and out_q are held stable while out_valid && !m_axis_tready[out_q].
//  Queue mapping: q = s_axis_tdata[PRIO_OFFSET +: PRIO_WIDTH]. If q >= N_QUEUE, q is clamped to N_QUEUE-1.
//  FSM states and transitions:
//   IDLE: a beat is accepted (tvalid && tready) -> compute q and latch it as cur_q. Load the output register with that beat, out_q = q.
//     If tlast is 0 -> FWD; if tlast is 1 -> stay in IDLE (single-beat frame).
//   FWD: every accepted beat is loaded with out_q = cur_q. The priority field is ignored in this state.
//     Accepted beat with tlast = 1 -> IDLE.
//  Back-to-back frames: the first beat of frame N+1 may be accepted in the cycle after the last beat of frame N. No bubble is inserted.
//  Stall on a new queue: if frame N+1 targets a different queue while a beat of frame N is still stalled, input stays stalled. Strict frame order is kept.
//  Empty-keep beats: beats with tkeep = 0 are forwarded unchanged. No length check is performed.
//  Reset mid-frame: the partial frame is abandoned. The next accepted beat is treated as a first beat.
// CONFIGURATION
//  Macro PRIORITY_CLASSIFIER_STATS_EN.
//  With the macro defined: status_frame_count[i*32 +: 32] increments by 1 on each output handshake on queue i with tlast = 1.
//    The counter wraps 0xFFFFFFFF -> 0 and is cleared by rst.
//  Without the macro: the port exists and is tied to 0. No counter flops are synthesised.
// STRUCTURE
//  Package prio_sched_pkg holds the shared definitions:
//   N_QUEUE_MAX = 8, the queue index type (3 bits), the classifier state enum {IDLE, FWD}, STAT_WIDTH = 32.
//  Sub-module prio_clamp (combinational): priority field -> clamped queue index. It is reusable by the scheduler side.
//  The FSM, output register and counters stay inline in this module.
// TESTING
//  T1: 3-beat frame, prio 1, all ready = 1.
//    -> beats appear on queue 1 only, 1 clk after each input beat. tlast on beat 3. Count[1] = 1.
//  T2: prio field = 6 with N_QUEUE = 3.
//    -> whole frame on queue 2. m_axis_tvalid[1:0] stays 0.
//  T3: frame A (prio 0, 4 beats) then frame B (prio 2, 1 beat) back-to-back; ready[0] low for 5 clk during A.
//    -> s_axis_tready = 0 for those 5 clk. B arrives on queue 2 only after A's tlast handshake.
//  T4: prio changes to 2 in beat 2 of a prio-0 frame.
//    -> all beats stay on queue 0.
//  T5: rst asserted in beat 2 of a 4-beat frame.
//    -> outputs are 0 next clk. Beat 3 after reset is routed by its own priority field.
//  T6 (macro on): 2^32-1 frames preloaded via force, then 1 more frame on queue 0.
//    -> count[0] wraps to 0. Macro off: status_frame_count always 0.

Source files
------------

// File: rtl/prio_sched_pkg.sv
// Shared definitions for the packet-scheduling path.
// Queue index type, classifier FSM states and status counter width.
package prio_sched_pkg;

    localparam int N_QUEUE_MAX = 8;
    localparam int QIDX_W      = 3;
    localparam int STAT_WIDTH  = 32;

    typedef logic [QIDX_W-1:0] qidx_t;

    typedef enum logic {
        IDLE = 1'b0,
        FWD  = 1'b1
    } cls_state_e;

endpackage

// File: rtl/prio_clamp.sv
// Maps a raw priority field onto a queue index.
// Values beyond the last queue land on the lowest-priority queue.
module prio_clamp
    import prio_sched_pkg::*;
#(
    parameter int N_QUEUE    = 3,
    parameter int PRIO_WIDTH = 3
) (
    input  logic [PRIO_WIDTH-1:0] prio_i,
    output qidx_t                 q_o
);

    logic [31:0] prio_ext;

    always_comb begin
        prio_ext = '0;
        prio_ext[PRIO_WIDTH-1:0] = prio_i;
        if (prio_ext >= 32'(N_QUEUE)) begin
            q_o = qidx_t'(N_QUEUE - 1);
        end else begin
            q_o = prio_ext[QIDX_W-1:0];
        end
    end

endmodule

// File: rtl/priority_classifier.sv
// Steers whole AXI-Stream frames to per-priority output queues.
// Per-queue frame counters exist only with PRIORITY_CLASSIFIER_STATS_EN.
module priority_classifier
    import prio_sched_pkg::*;
#(
    parameter int N_QUEUE         = 3,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int PRIO_OFFSET     = 0,
    parameter int PRIO_WIDTH      = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic [N_QUEUE*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [N_QUEUE*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [N_QUEUE-1:0]                   m_axis_tvalid,
    input  logic [N_QUEUE-1:0]                   m_axis_tready,
    output logic [N_QUEUE-1:0]                   m_axis_tlast,
    output logic [N_QUEUE*STAT_WIDTH-1:0]        status_frame_count
);

    cls_state_e                 state_q, state_d;
    qidx_t                      cur_q_q, cur_q_d;
    qidx_t                      clamp_q;
    qidx_t                      sel_q;

    logic                       out_valid_q, out_valid_d;
    qidx_t                      out_q_q, out_q_d;
    logic [AXIS_DATA_WIDTH-1:0] data_q, data_d;
    logic [AXIS_KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                       last_q, last_d;

    logic                       sel_ready;
    logic                       s_ready;
    logic                       accept;
    logic [PRIO_WIDTH-1:0]      prio_fld;

    assign prio_fld = s_axis_tdata[PRIO_OFFSET +: PRIO_WIDTH];

    prio_clamp #(
        .N_QUEUE   (N_QUEUE),
        .PRIO_WIDTH(PRIO_WIDTH)
    ) u_clamp (
        .prio_i(prio_fld),
        .q_o   (clamp_q)
    );

    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < N_QUEUE; i++) begin
            if (out_q_q == QIDX_W'(i)) begin
                sel_ready = m_axis_tready[i];
            end
        end
    end

    // A stalled beat blocks all input, so a new frame never overtakes it.
    assign s_ready       = !out_valid_q || sel_ready;
    assign s_axis_tready = !rst && s_ready;
    assign accept        = s_axis_tvalid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q_q <= cur_q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !s_axis_tlast) begin
                    state_d = FWD;
                end
            end
            FWD: begin
                if (accept && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_q   = cur_q_q;
        cur_q_d = cur_q_q;
        if (state_q == IDLE) begin
            sel_q = clamp_q;
            if (accept) begin
                cur_q_d = clamp_q;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        data_d      = data_q;
        keep_d      = keep_q;
        last_d      = last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_q_d     = sel_q;
            data_d      = s_axis_tdata;
            keep_d      = s_axis_tkeep;
            last_d      = s_axis_tlast;
        end else if (out_valid_q && sel_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        m_axis_tvalid = '0;
        for (int i = 0; i < N_QUEUE; i++) begin
            m_axis_tvalid[i] = !rst && out_valid_q && (out_q_q == QIDX_W'(i));
        end
    end

    assign m_axis_tdata = {N_QUEUE{data_q}};
    assign m_axis_tkeep = {N_QUEUE{keep_q}};
    assign m_axis_tlast = {N_QUEUE{last_q}};

`ifdef PRIORITY_CLASSIFIER_STATS_EN
    for (genvar g = 0; g < N_QUEUE; g++) begin : g_stats
        logic [STAT_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (m_axis_tvalid[g] && m_axis_tready[g] && last_q) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign status_frame_count[g*STAT_WIDTH +: STAT_WIDTH] = cnt_q;
    end
`else
    assign status_frame_count = '0;
`endif

endmodule

// File: tb/tb_priority_classifier.sv
// Scoreboard bench for priority_classifier: directed frames, decoupled monitor.
// Build with PRIORITY_CLASSIFIER_STATS_EN to exercise the frame counters.
module tb_priority_classifier;

    localparam int NQ = 3;
    localparam int W  = 64;
    localparam int K  = 8;

    logic            clk;
    logic            rst;
    logic [W-1:0]    s_axis_tdata;
    logic [K-1:0]    s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [NQ*W-1:0] m_axis_tdata;
    logic [NQ*K-1:0] m_axis_tkeep;
    logic [NQ-1:0]   m_axis_tvalid;
    logic [NQ-1:0]   m_axis_tready;
    logic [NQ-1:0]   m_axis_tlast;
    logic [NQ*32-1:0] status_frame_count;

    priority_classifier #(
        .N_QUEUE        (NQ),
        .AXIS_DATA_WIDTH(W),
        .AXIS_KEEP_WIDTH(K),
        .PRIO_OFFSET    (0),
        .PRIO_WIDTH     (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .status_frame_count(status_frame_count)
    );

    typedef struct {
        int           q;
        logic [W-1:0] d;
        logic [K-1:0] k;
        logic         l;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_cnt[NQ];
    int          n_chk  = 0;
    int          n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample just before the edge where the handshake happens.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if ($countones(m_axis_tvalid) > 1) begin
                n_chk++;
                n_fail++;
                $display("FAIL onehot: tvalid %b", m_axis_tvalid);
            end
            for (int i = 0; i < NQ; i++) begin
                if (m_axis_tvalid[i] && m_axis_tready[i]) begin
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected beat on q%0d data %h",
                                 i, m_axis_tdata[i*W +: W]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (i != e.q || m_axis_tdata[i*W +: W] !== e.d ||
                            m_axis_tkeep[i*K +: K] !== e.k ||
                            m_axis_tlast[i] !== e.l) begin
                            n_fail++;
                            $display("FAIL beat: got q%0d %h k%h l%b expected q%0d %h k%h l%b",
                                     i, m_axis_tdata[i*W +: W],
                                     m_axis_tkeep[i*K +: K], m_axis_tlast[i],
                                     e.q, e.d, e.k, e.l);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [K-1:0] k,
                        input logic l, input int q);
        int t;
        exp_t e;
        t = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!s_axis_tready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send timeout: data %h", d);
        end else begin
            e.q = q;
            e.d = d;
            e.k = k;
            e.l = l;
            sb.push_back(e);
`ifdef PRIORITY_CLASSIFIER_STATS_EN
            if (l) exp_cnt[q] = exp_cnt[q] + 32'd1;
`endif
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_counts(input string name);
        for (int i = 0; i < NQ; i++) begin
            check($sformatf("%s_cnt%0d", name, i),
                  64'(status_frame_count[i*32 +: 32]), 64'(exp_cnt[i]));
        end
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = '1;
        for (int i = 0; i < NQ; i++) exp_cnt[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_tdata", m_axis_tdata[63:0], 64'd0);
        check_counts("rst");
        @(negedge clk);
        rst = 1'b0;

        // T1: prio 1, middle beat carries keep 0 and a stray prio value
        send(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, 1);
        send(64'h0123_4567_89AB_CDEF, 8'h00, 1'b0, 1);
        send(64'hCAFE_F00D_0000_0003, 8'h0F, 1'b1, 1);

        // T2: prio 6 clamps to queue 2
        send(64'h5555_0000_0000_0006, 8'hFF, 1'b0, 2);
        send(64'h6666_0000_0000_0001, 8'h3F, 1'b1, 2);

        // T3: frame A on q0 stalled 5 clk, frame B on q2 follows
        fork
            begin
                send(64'hA000_0000_0000_0000, 8'hFF, 1'b0, 0);
                send(64'hA111_0000_0000_0001, 8'hFF, 1'b0, 0);
                send(64'hA222_0000_0000_0002, 8'hFF, 1'b0, 0);
                send(64'hA333_0000_0000_0000, 8'h01, 1'b1, 0);
                send(64'hB000_0000_0000_0002, 8'hFF, 1'b1, 2);
            end
            begin
                repeat (2) @(negedge clk);
                m_axis_tready[0] = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    check($sformatf("t3_stall%0d", c),
                          64'(s_axis_tready), 64'd0);
                    @(negedge clk);
                end
                m_axis_tready[0] = 1'b1;
            end
        join

        // T4: priority change mid-frame is ignored
        send(64'h4000_0000_0000_0000, 8'hFF, 1'b0, 0);
        send(64'h4111_0000_0000_0002, 8'hFF, 1'b0, 0);
        send(64'h4222_0000_0000_0002, 8'hFF, 1'b1, 0);

        drain("drain_a");
        check_counts("mid");

        // T5: reset after beat 2 of a 4-beat frame
        send(64'h5000_0000_0000_0000, 8'hFF, 1'b0, 0);
        send(64'h5111_0000_0000_0000, 8'hFF, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_tready", 64'(s_axis_tready), 64'd0);
        check("t5_tdata", m_axis_tdata[63:0], 64'd0);
        check("t5_tlast", 64'(m_axis_tlast), 64'd0);
        sb.delete();
        for (int i = 0; i < NQ; i++) exp_cnt[i] = '0;
        check_counts("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        send(64'h5222_0000_0000_0002, 8'hFF, 1'b0, 2);
        send(64'h5333_0000_0000_0000, 8'hFF, 1'b1, 2);
        drain("drain_b");
        check_counts("t5");

`ifdef PRIORITY_CLASSIFIER_STATS_EN
        // T6: counter wrap on queue 0
        force dut.g_stats[0].cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.g_stats[0].cnt_q;
        exp_cnt[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        check_counts("t6_pre");
        send(64'h6000_0000_0000_0000, 8'hFF, 1'b1, 0);
        drain("drain_c");
        check_counts("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
